// File: rtl/dac_sched_pkg.sv
// Shared defaults, FSM state type and source encodings for the DAC sample scheduler.
// Software may load DAC_MIDSCALE to park the DAC output at the centre of its range.
package dac_sched_pkg;

    localparam int DW_DEF         = 10;
    localparam int DIV_W_DEF      = 16;
    localparam int FIFO_DEPTH_DEF = 4;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_RAMP   = 1'b1;

    localparam logic [DW_DEF-1:0] DAC_MIDSCALE = 10'h200;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        RUN_STREAM = 2'd1,
        RUN_RAMP   = 2'd2
    } sched_state_e;

    // The source mode is only looked at when leaving IDLE, so it maps straight to a run state.
    function automatic sched_state_e run_state_for(input logic mode);
        return (mode == MODE_RAMP) ? RUN_RAMP : RUN_STREAM;
    endfunction

endpackage

// File: rtl/dac_sample_sched_fifo.sv
// Small synchronous FIFO holding CPU samples until the scheduler releases them.
// DEPTH must be a power of two so the pointers wrap for free.
module sample_fifo #(
    parameter int DW    = 10,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic [LW-1:0] level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          push_ok;
    logic          pop_ok;

    // Full/empty come from the registered level, so a pop never frees room for a same-cycle push.
    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_comb begin
        level_d = level_q;
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/dac_sample_sched.sv
// Paces the 10-bit DAC code: one sample per programmable period, taken either from the
// CPU sample FIFO or from a free-running ramp used during bring-up.
module dac_sample_sched
    import dac_sched_pkg::*;
#(
    parameter int DW         = DW_DEF,
    parameter int DIV_W      = DIV_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk_arun,
    input  logic             reset,
    input  logic             cfg_en,
    input  logic             cfg_mode,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [DW-1:0]    cpu_data,
    input  logic             cpu_valid,
    output logic             cpu_ready,
    output logic [DW-1:0]    dac_d,
    output logic             dac_strobe,
    output logic [LW-1:0]    fifo_level,
    output logic             underrun,
    input  logic             underrun_clr
);

    sched_state_e     state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic [DIV_W-1:0] period_q;
    logic [DIV_W-1:0] period_eff;
    logic             tick_q;
    logic             tick_d;
    logic [DW-1:0]    ramp_q;
    logic [DW-1:0]    dac_q;
    logic             strobe_q;
    logic             underrun_q;

    logic             running;
    logic             stream_tick;
    logic             ramp_tick;
    logic             fifo_pop;
    logic             underrun_set;
    logic [DW-1:0]    fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    sample_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_arun),
        .rst_ni  (reset),
        .push_i  (cpu_valid),
        .data_i  (cpu_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign running = (state_q != IDLE);

    // A new period length is only picked up at the start of a period, so software can
    // rewrite cfg_div at any time without producing a truncated period.
    assign period_eff = (cnt_q == '0) ? cfg_div : period_q;

    always_comb begin
        cnt_d  = '0;
        tick_d = 1'b0;
        if (running && cfg_en) begin
            if (cnt_q == period_eff) begin
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    // The tick is registered, so the pop/ramp step that consumes it lands one cycle later.
    assign stream_tick  = tick_q && (state_q == RUN_STREAM);
    assign ramp_tick    = tick_q && (state_q == RUN_RAMP);
    assign fifo_pop     = stream_tick && !fifo_empty;
    assign underrun_set = stream_tick && fifo_empty;

    always_ff @(posedge clk_arun or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            tick_q     <= 1'b0;
            ramp_q     <= '0;
            dac_q      <= '0;
            strobe_q   <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfg_en) state_q <= run_state_for(cfg_mode);
                end
                default: begin
                    if (!cfg_en) state_q <= IDLE;
                end
            endcase

            cnt_q    <= cnt_d;
            period_q <= period_eff;
            tick_q   <= tick_d;
            strobe_q <= fifo_pop || ramp_tick;

            if (fifo_pop) begin
                dac_q <= fifo_head;
            end else if (ramp_tick) begin
                dac_q  <= ramp_q;
                ramp_q <= ramp_q + DW'(1);
            end

            // A fresh underrun must not be lost to a clear issued in the same cycle.
            if (underrun_set) begin
                underrun_q <= 1'b1;
            end else if (underrun_clr) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign cpu_ready  = !fifo_full;
    assign dac_d      = dac_q;
    assign dac_strobe = strobe_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_dac_sample_sched.sv
// Self-checking bench for dac_sample_sched: directed scenarios followed by a random run,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_dac_sample_sched;

    localparam int DEPTH = 4;

    logic        clk_arun     = 1'b0;
    logic        reset        = 1'b0;
    logic        cfg_en       = 1'b0;
    logic        cfg_mode     = 1'b0;
    logic [15:0] cfg_div      = '0;
    logic [9:0]  cpu_data     = '0;
    logic        cpu_valid    = 1'b0;
    logic        underrun_clr = 1'b0;
    logic        cpu_ready;
    logic [9:0]  dac_d;
    logic        dac_strobe;
    logic [2:0]  fifo_level;
    logic        underrun;

    always #5 clk_arun = ~clk_arun;

    dac_sample_sched dut (
        .clk_arun     (clk_arun),
        .reset        (reset),
        .cfg_en       (cfg_en),
        .cfg_mode     (cfg_mode),
        .cfg_div      (cfg_div),
        .cpu_data     (cpu_data),
        .cpu_valid    (cpu_valid),
        .cpu_ready    (cpu_ready),
        .dac_d        (dac_d),
        .dac_strobe   (dac_strobe),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int strobeCyc[$];
    int strobeVal[$];

    // Behavioural model: mode 0 idle, 1 stream, 2 ramp; the FIFO is a plain queue and the
    // divider is tracked as "cycles into the current period" against a sampled period length.
    int mRun;
    int mPhase;
    int mLen;
    int mRamp;
    int mDac;
    bit mPend;
    bit mStrobe;
    bit mUnder;
    int mQ[$];

    task automatic modelReset();
        mRun    = 0;
        mPhase  = 0;
        mLen    = 1;
        mRamp   = 0;
        mDac    = 0;
        mPend   = 1'b0;
        mStrobe = 1'b0;
        mUnder  = 1'b0;
        mQ.delete();
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic modelEdge();
        bit canPush;
        bit act;
        bit newTick;
        bit setU;
        canPush = (mQ.size() < DEPTH);
        act     = mPend && (mRun != 0);
        newTick = 1'b0;
        setU    = 1'b0;
        if (mRun != 0 && cfg_en) begin
            if (mPhase == 0) mLen = int'(cfg_div) + 1;
            mPhase++;
            if (mPhase == mLen) begin
                newTick = 1'b1;
                mPhase  = 0;
            end
        end else begin
            mPhase = 0;
        end
        mStrobe = 1'b0;
        if (act && mRun == 1) begin
            if (mQ.size() > 0) begin
                mDac    = mQ.pop_front();
                mStrobe = 1'b1;
            end else begin
                setU = 1'b1;
            end
        end else if (act && mRun == 2) begin
            mDac    = mRamp;
            mRamp   = (mRamp + 1) % 1024;
            mStrobe = 1'b1;
        end
        if (cpu_valid && canPush) mQ.push_back(int'(cpu_data));
        if (setU) mUnder = 1'b1;
        else if (underrun_clr) mUnder = 1'b0;
        if (mRun == 0) begin
            if (cfg_en) mRun = cfg_mode ? 2 : 1;
        end else if (!cfg_en) begin
            mRun = 0;
        end
        mPend = newTick;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Compare every visible output against the model state.
    task automatic checkOutput();
        checkVal("dac_d", dac_d, mDac);
        checkVal("dac_strobe", dac_strobe, mStrobe);
        checkVal("underrun", underrun, mUnder);
        checkVal("fifo_level", fifo_level, mQ.size());
        checkVal("cpu_ready", cpu_ready, (mQ.size() < DEPTH) ? 1 : 0);
    endtask

    // One clock: wait for the edge, sample 1ns later, step the model and compare.
    task automatic applyStimulus();
        @(posedge clk_arun);
        #1;
        cyc++;
        if (!reset) modelReset();
        else modelEdge();
        checkOutput();
        if (dac_strobe === 1'b1) begin
            strobeCyc.push_back(cyc);
            strobeVal.push_back(int'(dac_d));
        end
    endtask

    task automatic resetDut();
        cfg_en       = 1'b0;
        cfg_mode     = 1'b0;
        cfg_div      = '0;
        cpu_valid    = 1'b0;
        cpu_data     = '0;
        underrun_clr = 1'b0;
        reset        = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        strobeCyc.delete();
        strobeVal.delete();
    endtask

    initial begin
        int enterCyc;
        int prevVal;
        bit sawWrap;
        bit seen;

        modelReset();

        // Reset values held while reset is low.
        $display("[TB] reset state");
        resetDut();
        checkVal("rst_dac_d", dac_d, 0);
        checkVal("rst_strobe", dac_strobe, 0);
        checkVal("rst_underrun", underrun, 0);
        checkVal("rst_level", fifo_level, 0);
        checkVal("rst_ready", cpu_ready, 1);

        // Stream pacing with period 4, three samples, then underrun.
        $display("[TB] stream pacing");
        cfg_en = 1'b1; cfg_mode = 1'b0; cfg_div = 16'd3;
        cpu_valid = 1'b1; cpu_data = 10'h005;
        applyStimulus();
        enterCyc = cyc;
        cpu_data = 10'h0A0;
        applyStimulus();
        cpu_data = 10'h3FF;
        applyStimulus();
        cpu_valid = 1'b0;
        for (int i = 0; i < 40 && underrun !== 1'b1; i++) applyStimulus();
        checkVal("underrun_after_drain", underrun, 1);
        checkVal("underrun_cycle", cyc - enterCyc, 17);
        checkVal("dac_hold_3ff", dac_d, 10'h3FF);
        checkVal("strobe_count", strobeCyc.size(), 3);
        if (strobeCyc.size() >= 3) begin
            checkVal("first_strobe_delay", strobeCyc[0] - enterCyc, 5);
            checkVal("strobe_gap_1", strobeCyc[1] - strobeCyc[0], 4);
            checkVal("strobe_gap_2", strobeCyc[2] - strobeCyc[1], 4);
            checkVal("sample_0", strobeVal[0], 10'h005);
            checkVal("sample_1", strobeVal[1], 10'h0A0);
            checkVal("sample_2", strobeVal[2], 10'h3FF);
        end

        // Fill the FIFO past capacity while disabled, then pop and push together at full.
        $display("[TB] fifo full");
        resetDut();
        cpu_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_data = 10'(16'h100 + i);
            applyStimulus();
            if (i == 3) begin
                checkVal("ready_at_full", cpu_ready, 0);
                checkVal("level_at_full", fifo_level, 4);
            end
        end
        checkVal("level_after_5th", fifo_level, 4);
        cfg_en = 1'b1; cfg_mode = 1'b0; cfg_div = 16'd0; cpu_data = 10'h2AA;
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkVal("pushpop_full_level", fifo_level, 3);
        checkVal("pushpop_full_data", dac_d, 10'h100);
        checkVal("pushpop_full_strobe", dac_strobe, 1);
        cpu_valid = 1'b0;
        cfg_en = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();

        // Ramp source at full rate, across the 1023 -> 0 wrap, with FIFO contents untouched.
        $display("[TB] ramp");
        resetDut();
        cpu_valid = 1'b1; cpu_data = 10'h033;
        applyStimulus();
        cpu_data = 10'h044;
        applyStimulus();
        cpu_valid = 1'b0;
        strobeCyc.delete(); strobeVal.delete();
        cfg_en = 1'b1; cfg_mode = 1'b1; cfg_div = 16'd0;
        sawWrap = 1'b0;
        prevVal = -1;
        for (int i = 0; i < 1030; i++) begin
            applyStimulus();
            if (dac_strobe === 1'b1) begin
                if (prevVal == 1023 && dac_d === 10'd0) sawWrap = 1'b1;
                prevVal = int'(dac_d);
            end
        end
        checkVal("ramp_wrapped", sawWrap, 1);
        checkVal("ramp_first_value", strobeVal.size() > 0 ? strobeVal[0] : -1, 0);
        checkVal("ramp_level_kept", fifo_level, 2);

        // Mode change while running is ignored until the block passes through IDLE.
        $display("[TB] mode change");
        resetDut();
        cpu_valid = 1'b1; cpu_data = 10'h155;
        cfg_en = 1'b1; cfg_mode = 1'b0; cfg_div = 16'd1;
        applyStimulus();
        cpu_valid = 1'b0;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkVal("stream_before_switch", dac_d, 10'h155);
        cfg_mode = 1'b1;
        strobeCyc.delete(); strobeVal.delete();
        for (int i = 0; i < 8; i++) applyStimulus();
        checkVal("no_strobe_after_switch", strobeCyc.size(), 0);
        cfg_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkVal("dac_held_idle", dac_d, 10'h155);
        end
        cfg_en = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus();
            seen = (dac_strobe === 1'b1);
        end
        checkVal("ramp_after_reenable", seen, 1);
        checkVal("ramp_after_reenable_val", dac_d, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            applyStimulus();
            seen = (dac_strobe === 1'b1);
        end
        checkVal("ramp_second_val", dac_d, 1);

        // Underrun: a set coinciding with a clear wins, a clear on a quiet cycle clears.
        $display("[TB] underrun clear");
        resetDut();
        cfg_en = 1'b1; cfg_mode = 1'b0; cfg_div = 16'd2;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            applyStimulus();
            seen = (underrun === 1'b1);
        end
        checkVal("underrun_set", seen, 1);
        applyStimulus();
        applyStimulus();
        underrun_clr = 1'b1;
        applyStimulus();
        checkVal("set_beats_clear", underrun, 1);
        applyStimulus();
        checkVal("quiet_clear", underrun, 0);
        underrun_clr = 1'b0;
        cfg_en = 1'b0;
        applyStimulus();

        // Asynchronous reset in the middle of a period with two samples queued.
        $display("[TB] mid-period reset");
        resetDut();
        cfg_en = 1'b1; cfg_mode = 1'b0; cfg_div = 16'd4;
        cpu_valid = 1'b1; cpu_data = 10'h1C3;
        applyStimulus();
        cpu_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            applyStimulus();
            seen = (underrun === 1'b1);
        end
        checkVal("pre_reset_underrun", seen, 1);
        cpu_valid = 1'b1; cpu_data = 10'h011;
        applyStimulus();
        cpu_data = 10'h022;
        applyStimulus();
        cpu_valid = 1'b0;
        applyStimulus();
        checkVal("pre_reset_level", fifo_level, 2);
        checkVal("pre_reset_dac", dac_d, 10'h1C3);
        #3;
        reset = 1'b0;
        cfg_en = 1'b0;
        #1;
        modelReset();
        checkVal("async_dac", dac_d, 0);
        checkVal("async_level", fifo_level, 0);
        checkVal("async_underrun", underrun, 0);
        checkVal("async_strobe", dac_strobe, 0);
        checkVal("async_ready", cpu_ready, 1);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        strobeCyc.delete(); strobeVal.delete();
        for (int i = 0; i < 8; i++) applyStimulus();
        checkVal("idle_after_reset", strobeCyc.size(), 0);

        // Random traffic against the model.
        $display("[TB] random");
        resetDut();
        cfg_en = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 9) == 0) cfg_mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) cfg_div = 16'($urandom_range(0, 5));
            cpu_valid    = 1'($urandom_range(0, 1));
            cpu_data     = 10'($urandom_range(0, 1023));
            underrun_clr = ($urandom_range(0, 7) == 0);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dac_sample_sched.md
Name: dac_sample_sched

Overview:
- Paces and sources the 10-bit code driven into the SoC DAC.
- Buffers CPU-produced samples in a small FIFO and releases one sample per programmable sample period.
- Also offers a built-in ramp test source for bring-up.
- Sits between the RISC-V core output and the DAC digital input, clocked by the PLL output clock.

Parameters:
- DW, 10, DAC code width.
- DIV_W, 16, width of the sample-period divider.
- FIFO_DEPTH, 4, CPU sample FIFO entries (power of two, at least 2).

Ports:
- clk_arun  input  1  PLL-generated system clock.
- reset  input  1  asynchronous, active-low reset.
- cfg_en  input  1  scheduler enable.
- cfg_mode  input  1  source select: 0 = CPU stream, 1 = ramp test.
- cfg_div  input  DIV_W  sample period minus 1, in clk_arun cycles.
- cpu_data  input  DW  sample from the core.
- cpu_valid  input  1  cpu_data is valid.
- cpu_ready  output  1  FIFO can accept a sample.
- dac_d  output  DW  code to the DAC D input.
- dac_strobe  output  1  one-cycle pulse when dac_d updates.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- underrun  output  1  sticky: a stream tick found the FIFO empty.
- underrun_clr  input  1  clears underrun.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, dac_d=0, dac_strobe=0, underrun=0, FIFO empty (fifo_level=0), divider count=0, ramp=0, cpu_ready=1.
- FSM states: IDLE, RUN_STREAM, RUN_RAMP.
  - IDLE: counter held at 0. If cfg_en=1, latch cfg_mode and go to RUN_STREAM (mode 0) or RUN_RAMP (mode 1) on the next edge.
  - Either RUN state: if cfg_en=0, return to IDLE on the next edge. dac_d holds its value; FIFO contents are kept.
  - cfg_mode changes while running are ignored until the block passes through IDLE again.
- Divider:
  - In a RUN state, the counter increments each cycle. A tick occurs when count equals the period value, and the counter then returns to 0.
  - The period value is cfg_div, sampled when the counter is 0.
  - Period is cfg_div+1 cycles. cfg_div=0 gives a tick every cycle.
  - First tick occurs cfg_div+1 cycles after entering the RUN state.
- Stream tick:
  - FIFO non-empty: pop the head into dac_d and pulse dac_strobe in the same registered cycle (1 cycle after the tick).
  - FIFO empty: set underrun, leave dac_d unchanged, no strobe.
- Ramp tick: dac_d <= ramp; ramp <= ramp+1, wrapping from 2^DW-1 to 0; dac_strobe pulses.
- FIFO behaviour:
  - Accepts pushes in every state.
  - cpu_ready = (fifo_level != FIFO_DEPTH), based on registered occupancy.
  - Push happens on cpu_valid && cpu_ready.
  - Ramp mode never pops the FIFO.
  - Push and pop in the same cycle: level unchanged, ordering preserved.
  - When full, a push is refused even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- underrun flag:
  - Cleared by underrun_clr.
  - If set and clear happen in the same cycle, set wins.
  - Not affected by cfg_en.
- Mid-operation reset: all state returns to reset values immediately; no strobe is generated.

Decomposition:
- Package dac_sched_pkg: DW/DIV_W defaults, state enum (IDLE, RUN_STREAM, RUN_RAMP), mode encodings (MODE_STREAM=0, MODE_RAMP=1), midscale constant for software use.
- Sub-module sample_fifo: parameterised synchronous FIFO (DW, FIFO_DEPTH) with push/pop/level/full/empty.
- The top holds the FSM, divider, ramp and underrun logic.

Test Plan:
- Reset, then cfg_en=1, mode=0, cfg_div=3, push 0x005, 0x0A0, 0x3FF.
  - Expect dac_d = 0x005, 0x0A0, 0x3FF with strobes exactly 4 cycles apart.
  - First strobe 5 cycles after entering RUN_STREAM.
  - After that, underrun=1 on the next tick and dac_d holds 0x3FF.
- Push 5 samples with FIFO_DEPTH=4 while cfg_en=0.
  - cpu_ready=0 after the 4th push; 5th not accepted; fifo_level=4.
  - Same-cycle push+pop at full: push refused, level becomes 3.
- Mode 1, cfg_div=0, start from reset.
  - dac_d counts 0,1,2,… one strobe per cycle, wraps 1023->0.
  - FIFO level unchanged throughout.
- Change cfg_mode 0->1 while running: no effect.
  - Deassert cfg_en, reassert: ramp source selected; dac_d held during IDLE.
- Set underrun, then pulse underrun_clr on the same cycle as a new empty-FIFO tick: underrun stays 1.
  - Clear on a quiet cycle: underrun=0.
- Assert reset mid-period with 2 samples queued: dac_d=0, fifo_level=0, underrun=0, no strobe, state IDLE.
